// File: rtl/cnn_pkg.sv
// Shared sizes and FSM state type for the convolution result path.
package cnn_pkg;
  localparam int unsigned RES_W     = 30;
  localparam int unsigned RES_H     = 30;
  localparam int unsigned RES_WHOLE = RES_W * RES_H;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned PIX_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } rd_state_e;
endpackage

// File: rtl/conv_result_clamp.sv
// Saturates one stored convolution result to an 8-bit pixel, optionally with ReLU.
module conv_result_clamp #(
  parameter int unsigned DATA_W  = cnn_pkg::DATA_W,
  parameter int unsigned RELU_EN = 1
) (
  input  logic [DATA_W-1:0]         data,
  output logic [cnn_pkg::PIX_W-1:0] pix_c
);
  import cnn_pkg::*;

  localparam logic [DATA_W-1:0] PIX_MAX = DATA_W'(255);

  // Negative check only applies when results are signed.
  always_comb begin
    pix_c = data[PIX_W-1:0];
    if ((RELU_EN != 0) && data[DATA_W-1]) begin
      pix_c = '0;
    end else if (data > PIX_MAX) begin
      pix_c = '1;
    end
  end
endmodule

// File: rtl/conv_result_reader.sv
// Streams one frame out of the result buffer as clamped 8-bit pixels on a
// valid/ready interface with end-of-line and end-of-frame markers.
module conv_result_reader #(
  parameter int unsigned RES_W   = cnn_pkg::RES_W,
  parameter int unsigned RES_H   = cnn_pkg::RES_H,
  parameter int unsigned DATA_W  = cnn_pkg::DATA_W,
  parameter int unsigned RELU_EN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  output logic [cnn_pkg::ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [cnn_pkg::PIX_W-1:0]  out_data,
  output logic                       out_eol,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);
  import cnn_pkg::*;

  localparam int unsigned COL_W = (RES_W > 1) ? $clog2(RES_W) : 1;
  localparam int unsigned ROW_W = (RES_H > 1) ? $clog2(RES_H) : 1;

  rd_state_e          state;
  rd_state_e          next_state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [PIX_W-1:0]   pix_c;
  logic               xfer;
  logic               load;
  logic               col_end;
  logic               row_end;

  assign xfer    = out_valid & out_ready;
  assign load    = (state == STREAM) & (~out_valid | xfer);
  assign col_end = (col == COL_W'(RES_W - 1));
  assign row_end = (row == ROW_W'(RES_H - 1));

  conv_result_clamp #(
    .DATA_W  (DATA_W),
    .RELU_EN (RELU_EN)
  ) u_clamp (
    .data  (rd_data),
    .pix_c (pix_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort overrides every transition, including start and a pending transfer.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = STREAM;
        STREAM:  if (load && col_end && row_end) next_state = DRAIN;
        DRAIN:   if (xfer) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output register, address and row/column tracking; address wraps to 0
  // on the final load so it never points past the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr   <= '0;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      rd_addr   <= '0;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == DRAIN) & xfer;
      busy <= (next_state != IDLE);
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= pix_c;
        out_eol   <= col_end;
        out_last  <= col_end & row_end;
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        rd_addr <= (col_end && row_end) ? '0 : rd_addr + ADDR_W'(1);
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_result_reader.sv
// Directed bench for conv_result_reader: streaming, backpressure, clamping,
// restart/abort behaviour and asynchronous reset mid-frame.
module tb_conv_result_reader;
  import cnn_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] rd_addr, rd_addr_u;
  logic [DATA_W-1:0] rd_data, rd_data_u;
  logic              out_valid, out_valid_u;
  logic [PIX_W-1:0]  out_data, out_data_u;
  logic              out_eol, out_eol_u, out_last, out_last_u;
  logic              busy, busy_u, done, done_u;

  int passed = 0;
  int total  = 0;
  int idx    = 0;
  int exp_relu [4] = '{0, 0, 127, 255};
  int exp_raw  [4] = '{255, 0, 127, 255};

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] tbl(input logic [ADDR_W-1:0] a);
    case (a)
      10'd0:   return 16'hFFF0;
      10'd1:   return 16'h0000;
      10'd2:   return 16'h007F;
      10'd3:   return 16'h0100;
      default: return 16'h0000;
    endcase
  endfunction

  assign rd_data   = mode ? tbl(rd_addr) : DATA_W'(rd_addr);
  assign rd_data_u = tbl(rd_addr_u);

  conv_result_reader #(.RELU_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_eol(out_eol),
    .out_last(out_last), .busy(busy), .done(done)
  );

  conv_result_reader #(.RELU_EN(0)) dut_u (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_addr(rd_addr_u), .rd_data(rd_data_u), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_data(out_data_u), .out_eol(out_eol_u),
    .out_last(out_last_u), .busy(busy_u), .done(done_u)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Starts a frame from a negedge and checks transfers until stop_at pixels
  // have moved; for a full frame also checks the done pulse.
  task automatic stream(input bit bp, input int stop_at, input int repulse_at);
    int guard = 0;
    int early_done = 0;
    bit stall_prev = 1'b0;
    logic [PIX_W-1:0]  pd = '0;
    logic              pe = 1'b0, pl = 1'b0;
    logic [ADDR_W-1:0] pa = '0;
    idx = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("lat_not_valid", out_valid, 0);
    check("lat_busy", busy, 1);
    check("done_single", done, 0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    while (idx < stop_at && guard < 20000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (repulse_at >= 0) && (idx == repulse_at);
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, pd);
        check("stall_eol", out_eol, pe);
        check("stall_last", out_last, pl);
        check("stall_addr", rd_addr, pa);
      end
      if (done) early_done++;
      if (out_valid && out_ready) begin
        check("data", out_data, (idx > 255) ? 255 : idx);
        check("eol", out_eol, int'((idx % RES_W) == RES_W - 1));
        check("last", out_last, int'(idx == RES_WHOLE - 1));
        idx++;
      end
      stall_prev = out_valid && !out_ready;
      pd = out_data; pe = out_eol; pl = out_last; pa = rd_addr;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("xfer_count", idx, stop_at);
    check("no_early_done", early_done, 0);
    if (stop_at == RES_WHOLE) begin
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_valid", out_valid, 0);
    end
  endtask

  initial begin
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_data", out_data, 0);
    #11 reset = 1'b1;
    @(negedge clk);

    // Clamp vectors on both ReLU and unsigned instances.
    mode = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("relu_pix", out_data, exp_relu[i]);
      check("raw_pix", out_data_u, exp_raw[i]);
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    mode = 1'b0;
    check("clamp_abort_valid", out_valid, 0);
    check("clamp_abort_busy", busy, 0);
    @(negedge clk);

    // Full frame, then a back-to-back frame under random backpressure.
    stream(1'b0, RES_WHOLE, -1);
    stream(1'b1, RES_WHOLE, -1);
    @(negedge clk);
    check("done_cleared", done, 0);

    // Re-pulsed start is ignored; abort wins over start and a transfer.
    stream(1'b0, 200, 100);
    check("pre_abort_addr", rd_addr, 201);
    abort = 1'b1; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", rd_addr, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_idle_done", done, 0);
    check("abort_idle_busy", busy, 0);
    stream(1'b0, RES_WHOLE, -1);
    @(negedge clk);

    // Asynchronous reset mid-frame, then a fresh frame.
    stream(1'b0, 450, -1);
    #3 reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_eol", out_eol, 0);
    check("arst_last", out_last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_addr", rd_addr, 0);
    @(negedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    stream(1'b1, RES_WHOLE, -1);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/conv_result_reader.md
CONV_RESULT_READER -- requirements
Module: conv_result_reader

Interface
REQ-001 Parameter RES_W, default 30, result-map width in pixels.
REQ-002 Parameter RES_H, default 30, result-map height in pixels.
REQ-003 Parameter DATA_W, default 16, width of one stored convolution result.
REQ-004 Parameter RELU_EN, default 1; 1 clamps negative results to 0, 0 treats results as unsigned.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to stream one full frame.
REQ-008 abort  input  1  synchronous frame cancel.
REQ-009 rd_addr  output  10  result-buffer read address, drives the buffer's ReadReg port.
REQ-010 rd_data  input  DATA_W  result-buffer read data; combinational, valid in the same cycle as rd_addr.
REQ-011 out_valid  output  1  out_data holds a valid pixel.
REQ-012 out_ready  input  1  downstream accepts the pixel.
REQ-013 out_data  output  8  clamped pixel.
REQ-014 out_eol  output  1  the current pixel is the last column of its row.
REQ-015 out_last  output  1  the current pixel is the last pixel of the frame (index RES_W*RES_H-1).
REQ-016 busy  output  1  a frame is in progress.
REQ-017 done  output  1  one-cycle pulse after the last pixel transfers.

Function
REQ-018 FSM states: IDLE, STREAM, DRAIN.
- IDLE -> STREAM on start.
- STREAM -> DRAIN once the last pixel has been loaded into the output register.
- DRAIN -> IDLE on the transfer of the last pixel.
REQ-019 A transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-020 Output register load condition: state is STREAM and (out_valid=0 or transfer).
REQ-021 On a load, out_data, out_eol and out_last are captured from rd_addr and rd_data, and rd_addr increments.
REQ-022 rd_addr is 0 in IDLE; on start it stays 0, so pixel 0 loads on the first STREAM cycle.
REQ-023 Latency: start sampled at edge N; out_valid=1 with pixel 0 after edge N+1.
REQ-024 With out_ready held high, one pixel transfers per cycle; a frame completes in RES_W*RES_H cycles after the first out_valid.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_eol, out_last and rd_addr hold stable.
REQ-026 out_valid deasserts only after a transfer with no new load.
REQ-027 Row/column counters track the loaded pixel:
- out_eol=1 when column = RES_W-1; column then wraps to 0 and row increments.
- out_last=1 when row = RES_H-1 and column = RES_W-1.
REQ-028 Clamp with RELU_EN=1: rd_data is treated as signed; values < 0 give 0, values > 255 give 255, otherwise the low 8 bits.
REQ-029 Clamp with RELU_EN=0: rd_data is treated as unsigned; values > 255 give 255.
REQ-030 done=1 for exactly the cycle after the last transfer; busy=0 in that same cycle.
REQ-031 busy=1 in STREAM and DRAIN.
REQ-032 start while busy=1 is ignored.
REQ-033 start in the same cycle as done is accepted (back-to-back frames).
REQ-034 abort=1 in any state, on the next edge:
- FSM returns to IDLE; out_valid=0; rd_addr=0; counters=0.
- done is not pulsed.
- abort has priority over start and over a simultaneous transfer.
REQ-035 rd_addr never exceeds RES_W*RES_H-1.

Reset
REQ-036 reset=0 asynchronously forces the following, regardless of state, including mid-frame:
- FSM=IDLE.
- rd_addr=0, row=0, column=0.
- out_valid=0, out_data=0, out_eol=0, out_last=0.
- busy=0, done=0.
REQ-037 The first start after reset deasserts behaves per REQ-023.

Structure
REQ-038 Shared package cnn_pkg holds:
- RES_W, RES_H, RES_WHOLE (=900), DATA_W;
- the FSM state enumeration.
REQ-039 Clamping is a combinational sub-module conv_result_clamp (DATA_W in, 8 out, RELU_EN parameter); all other logic is in conv_result_reader.

Verification
REQ-040 Buffer model returns rd_data=addr; out_ready=1; start pulsed.
- Required: 900 transfers, data = min(addr,255) in order.
- out_eol on indices 29, 59, ..., 899; out_last only on 899.
- done one cycle after index 899.
REQ-041 Backpressure: out_ready toggles with a random pattern (about 50%).
- Required: no pixel lost or duplicated; outputs stable while stalled; still 900 transfers.
REQ-042 Clamp, RELU_EN=1, rd_data values 16'hFFF0, 16'h0000, 16'h007F, 16'h0100.
- Required: out_data = 0, 0, 127, 255.
REQ-043 Clamp, RELU_EN=0, same values.
- Required: out_data = 255, 0, 127, 255.
REQ-044 start re-pulsed at pixel 100; then abort at pixel 200.
- Required: the re-pulse is ignored; after abort, out_valid=0 next cycle, no done, IDLE.
- A following start restarts at address 0.
REQ-045 reset=0 asserted mid-frame at pixel 450, asynchronous to clk.
- Required: all outputs 0 immediately.
- A fresh start streams a full frame from index 0.
